scroll_sequencer: RTL and testbench

Sequencing controller for the scrolling message display. It accepts a message character by character over a valid/ready load port and stores it in an internal buffer. A speed-selectable prescaler, which gives single-cycle enables on `clk_in` rather than a derived clock, advances a circular window offset. The block presents `NUM_DIGITS` characters to the seven-segment decode stage. It sits between the message source (switches or UART front end) and the per-digit decoders, and it replaces divided-clock scrolling with a single clock domain.

---
 rtl/scroll_pkg.sv | 27 ++
 rtl/scroll_prescaler.sv | 49 ++++
 rtl/scroll_sequencer.sv | 177 +++++++++++++++++
 tb/tb_scroll_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared types and constant helpers for the scrolling message
// sequencer.
//   scroll_state_t : FSM state encoding (IDLE/LOAD/SCROLL/PAUSE), also
//                    exported on the status port.
//   BLANK()        : all-ones character code for a given code width.
//   period()       : prescaler period in clk_in cycles for a step rate.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2,
    PAUSE  = 2'd3
  } scroll_state_t;

  // All-ones code of width char_w (char_w below 32).
  function automatic logic [31:0] BLANK(input int unsigned char_w);
    return ~(32'hFFFF_FFFF << char_w);
  endfunction

  // Number of clk_in cycles between scroll steps.
  function automatic int unsigned period(input int unsigned clk_hz,
                                         input int unsigned rate_hz);
    return clk_hz / rate_hz;
  endfunction

endpackage

// File: rtl/scroll_prescaler.sv
// scroll_prescaler: speed-selectable step-enable generator.
//   clk_in     : single clock
//   reset      : synchronous active-low; clears the count
//   speed_ctrl : 0 = SLOW_HZ period, 1 = FAST_HZ period
//   en         : count enable; count holds while low
//   tick       : combinational, high in the cycle the count sits at or past
//                the selected limit; the count clears on that edge
module scroll_prescaler
  import scroll_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned SLOW_HZ = 1,
  parameter int unsigned FAST_HZ = 10
) (
  input  logic clk_in,
  input  logic reset,
  input  logic speed_ctrl,
  input  logic en,
  output logic tick
);

  localparam int unsigned P_SLOW = period(CLK_HZ, SLOW_HZ);
  localparam int unsigned P_FAST = period(CLK_HZ, FAST_HZ);
  localparam int unsigned CNT_W  = (P_SLOW > 1) ? $clog2(P_SLOW) : 1;

  localparam logic [CNT_W-1:0] SLOW_LIM = CNT_W'(P_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_LIM = CNT_W'(P_FAST - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] limit;

  // ">=" rather than "==": after a slow-to-fast switch the count may already
  // be past the fast limit, and it must tick next instead of wrapping around.
  always_comb begin
    limit = speed_ctrl ? FAST_LIM : SLOW_LIM;
    tick  = en && (count_reg >= limit);
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: loads a message over a valid/ready port and presents a
// circular NUM_DIGITS-character window that scrolls on prescaler steps.
//   clk_in      : single clock, rising edge
//   reset       : synchronous active-low reset
//   speed_ctrl  : step rate select (0 slow, 1 fast)
//   run         : 1 scroll, 0 pause
//   dir         : 0 offset +1 (left), 1 offset -1 (right)
//   clear       : drop message, back to IDLE (outranks tick and load)
//   load_valid / load_char / load_last / load_ready : character load port
//   window      : NUM_DIGITS characters, digit 0 in the MS field
//   step_pulse  : one-cycle pulse per offset advance
//   state       : current FSM state
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SLOW_HZ    = 1,
  parameter int unsigned FAST_HZ    = 10,
  parameter int unsigned MSG_LEN    = 16,
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned CHAR_W     = 5
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         speed_ctrl,
  input  logic                         run,
  input  logic                         dir,
  input  logic                         clear,
  input  logic                         load_valid,
  input  logic [CHAR_W-1:0]            load_char,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic [NUM_DIGITS*CHAR_W-1:0] window,
  output logic                         step_pulse,
  output logic [1:0]                   state
);

  localparam int unsigned PTR_W = $clog2(MSG_LEN);
  localparam int unsigned LEN_W = $clog2(MSG_LEN + 1);
  localparam logic [CHAR_W-1:0] BLANK_CODE = CHAR_W'(BLANK(CHAR_W));

  scroll_state_t     state_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [PTR_W-1:0]  offset_reg;
  logic [PTR_W-1:0]  offset_next;
  logic              load_ready_reg;
  logic              step_pulse_reg;

  // Message store. Every digit reads it in parallel each cycle, so it is a
  // register file rather than a single-port RAM.
  logic [CHAR_W-1:0] msg_buf [MSG_LEN];

  logic active;
  logic presc_reset;
  logic presc_en;
  logic tick;
  logic xfer;
  logic wr_en;

  assign active = (state_reg == SCROLL) || (state_reg == PAUSE);
  assign xfer   = load_valid && load_ready_reg;
  assign wr_en  = xfer && reset && !clear;

  // The prescaler is held at zero outside SCROLL/PAUSE and on clear, so
  // entry from LOAD always starts the count from zero. It runs whenever run
  // is high while a message is displayed, including the PAUSE cycle in which
  // run returns, so the pause costs exactly the cycles spent with run low.
  assign presc_reset = reset && !clear && active;
  assign presc_en    = run && active;

  scroll_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .SLOW_HZ (SLOW_HZ),
    .FAST_HZ (FAST_HZ)
  ) u_prescaler (
    .clk_in     (clk_in),
    .reset      (presc_reset),
    .speed_ctrl (speed_ctrl),
    .en         (presc_en),
    .tick       (tick)
  );

  always_comb begin
    offset_next = offset_reg;
    if (!dir) begin
      offset_next = ((LEN_W'(offset_reg) + LEN_W'(1)) == len_reg) ?
                    '0 : offset_reg + PTR_W'(1);
    end else begin
      offset_next = (offset_reg == '0) ?
                    PTR_W'(len_reg - LEN_W'(1)) : offset_reg - PTR_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      msg_buf[wr_ptr_reg] <= load_char;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset || clear) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      len_reg        <= '0;
      offset_reg     <= '0;
      load_ready_reg <= 1'b1;
      step_pulse_reg <= 1'b0;
    end else begin
      step_pulse_reg <= 1'b0;
      if (tick) begin
        offset_reg     <= offset_next;
        step_pulse_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            wr_ptr_reg <= PTR_W'(1);
            if (load_last) begin
              len_reg        <= LEN_W'(1);
              offset_reg     <= '0;
              state_reg      <= SCROLL;
              load_ready_reg <= 1'b0;
            end else begin
              state_reg <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (load_last || (wr_ptr_reg == PTR_W'(MSG_LEN - 1))) begin
              len_reg        <= LEN_W'(wr_ptr_reg) + LEN_W'(1);
              offset_reg     <= '0;
              state_reg      <= run ? SCROLL : PAUSE;
              load_ready_reg <= 1'b0;
            end
          end
        end
        SCROLL: begin
          if (!run) begin
            state_reg <= PAUSE;
          end
        end
        PAUSE: begin
          if (run) begin
            state_reg <= SCROLL;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Window mux: digit gi shows msg_buf[(offset + gi) mod len]. len is never
  // zero while a message is displayed; the guard only keeps the modulo
  // defined in the other states, where the window is blanked anyway.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [PTR_W-1:0] rd_idx;
      logic [31:0]      len_safe;
      always_comb begin
        len_safe = (len_reg == '0) ? 32'd1 : 32'(len_reg);
        rd_idx   = PTR_W'((32'(offset_reg) + 32'(gi)) % len_safe);
      end
      assign window[(NUM_DIGITS-1-gi)*CHAR_W +: CHAR_W] =
        active ? msg_buf[rd_idx] : BLANK_CODE;
    end
  endgenerate

  assign load_ready = load_ready_reg;
  assign step_pulse = step_pulse_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_scroll_sequencer.sv
module tb_scroll_sequencer;

  localparam int unsigned CW = 5;
  localparam int unsigned ND = 4;
  localparam logic [19:0] ALL_BLANK = 20'hFFFFF;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             speed_ctrl;
  logic             run;
  logic             dir;
  logic             clear;
  logic             load_valid;
  logic [CW-1:0]    load_char;
  logic             load_last;
  logic             load_ready;
  logic [ND*CW-1:0] window;
  logic             step_pulse;
  logic [1:0]       state;

  int vectors     = 0;
  int miscompares = 0;

  scroll_sequencer #(
    .CLK_HZ     (20),
    .SLOW_HZ    (1),
    .FAST_HZ    (5),
    .MSG_LEN    (8),
    .NUM_DIGITS (ND),
    .CHAR_W     (CW)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .speed_ctrl (speed_ctrl),
    .run        (run),
    .dir        (dir),
    .clear      (clear),
    .load_valid (load_valid),
    .load_char  (load_char),
    .load_last  (load_last),
    .load_ready (load_ready),
    .window     (window),
    .step_pulse (step_pulse),
    .state      (state)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] win(input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] c, input logic [4:0] d);
    return {a, b, c, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input logic [4:0] ch, input logic last);
    load_valid = 1'b1;
    load_char  = ch;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Number of clocks until step_pulse is seen (0 if not within max_cycles).
  task automatic wait_pulse(input int max_cycles, output int n);
    n = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      step();
      if (step_pulse) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int pulses;

    reset      = 1'b0;
    speed_ctrl = 1'b0;
    run        = 1'b1;
    dir        = 1'b0;
    clear      = 1'b0;
    load_valid = 1'b0;
    load_char  = '0;
    load_last  = 1'b0;
    step();
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_window", 32'(window), 32'(ALL_BLANK));
    check("rst_pulse", 32'(step_pulse), 32'd0);
    reset = 1'b1;
    step();

    // Five-character message, left scroll, slow rate.
    load(5'd1, 1'b0);
    check("load1_state", 32'(state), 32'd1);
    check("load1_window", 32'(window), 32'(ALL_BLANK));
    load(5'd2, 1'b0);
    load(5'd3, 1'b0);
    load(5'd4, 1'b0);
    load(5'd5, 1'b1);
    check("last_state", 32'(state), 32'd2);
    check("last_ready", 32'(load_ready), 32'd0);
    check("win_off0", 32'(window), 32'(win(1, 2, 3, 4)));
    wait_pulse(100, n);
    check("first_step_gap", 32'(n), 32'd20);
    check("win_off1", 32'(window), 32'(win(2, 3, 4, 5)));
    step();
    check("pulse_one_cycle", 32'(step_pulse), 32'd0);
    wait_pulse(100, n);
    check("step_gap2", 32'(n), 32'd19);
    check("win_off2", 32'(window), 32'(win(3, 4, 5, 1)));
    wait_pulse(100, n);
    check("win_off3", 32'(window), 32'(win(4, 5, 1, 2)));
    wait_pulse(100, n);
    check("step_gap4", 32'(n), 32'd20);
    check("win_off4", 32'(window), 32'(win(5, 1, 2, 3)));
    wait_pulse(100, n);
    check("win_wrap0", 32'(window), 32'(win(1, 2, 3, 4)));

    // Right scroll from offset 0 wraps to len-1.
    dir = 1'b1;
    wait_pulse(100, n);
    check("dir1_wrap", 32'(window), 32'(win(5, 1, 2, 3)));
    wait_pulse(100, n);
    check("dir1_off3", 32'(window), 32'(win(4, 5, 1, 2)));

    // Slow-to-fast switch at count 10 ticks at once, then every 4 cycles.
    repeat (10) step();
    speed_ctrl = 1'b1;
    step();
    check("fast_switch_pulse", 32'(step_pulse), 32'd1);
    check("fast_switch_win", 32'(window), 32'(win(3, 4, 5, 1)));
    wait_pulse(100, n);
    check("fast_gap", 32'(n), 32'd4);
    check("fast_win", 32'(window), 32'(win(2, 3, 4, 5)));

    // Pause at count 7 for 50 cycles.
    speed_ctrl = 1'b0;
    repeat (7) step();
    run = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (step_pulse) pulses++;
    end
    check("pause_no_pulse", 32'(pulses), 32'd0);
    check("pause_state", 32'(state), 32'd3);
    check("pause_win_hold", 32'(window), 32'(win(2, 3, 4, 5)));
    run = 1'b1;
    wait_pulse(100, n);
    check("resume_gap", 32'(n), 32'd13);
    check("resume_win", 32'(window), 32'(win(1, 2, 3, 4)));

    // Clear in the tick cycle wins.
    repeat (19) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_pulse", 32'(step_pulse), 32'd0);
    check("clear_state", 32'(state), 32'd0);
    check("clear_window", 32'(window), 32'(ALL_BLANK));
    check("clear_ready", 32'(load_ready), 32'd1);

    // Eight characters with no load_last terminate at full depth.
    dir = 1'b0;
    for (int i = 0; i < 7; i++) load(5'(10 + i), 1'b0);
    check("full7_ready", 32'(load_ready), 32'd1);
    check("full7_state", 32'(state), 32'd1);
    load(5'd17, 1'b0);
    check("full8_ready", 32'(load_ready), 32'd0);
    check("full8_state", 32'(state), 32'd2);
    check("full8_win", 32'(window), 32'(win(10, 11, 12, 13)));
    load(5'd20, 1'b0);
    check("ninth_win", 32'(window), 32'(win(10, 11, 12, 13)));
    check("ninth_state", 32'(state), 32'd2);
    dir = 1'b1;
    wait_pulse(100, n);
    check("len8_wrap", 32'(window), 32'(win(17, 10, 11, 12)));

    // Reset in the middle of a load.
    clear = 1'b1;
    step();
    clear = 1'b0;
    load(5'd3, 1'b0);
    load(5'd4, 1'b0);
    check("midload_state", 32'(state), 32'd1);
    load_valid = 1'b1;
    load_char  = 5'd6;
    reset      = 1'b0;
    step();
    load_valid = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_ready", 32'(load_ready), 32'd1);
    check("midrst_window", 32'(window), 32'(ALL_BLANK));
    check("midrst_pulse", 32'(step_pulse), 32'd0);
    reset = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
